// File: rtl/dizy_key_sched_pkg.sv
// Shared constants for the DIZY key scheduler: per-variant sizes, FSM
// encoding and the ceiling-divide helper used to derive round/beat counts.
package dizy_key_sched_pkg;

    localparam int DIZY128_SIZE_STATE = 160;
    localparam int DIZY128_SIZE_KEY   = 128;
    localparam int DIZY80_SIZE_STATE  = 120;
    localparam int DIZY80_SIZE_KEY    = 80;
    localparam int DIZY_SBOX_W        = 5;
    localparam int DIZY_KBITS         = 2;
    localparam int DIZY_BUS_W         = 32;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_ARMED   = 2'd2
    } state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int num_sbox(input int size_state, input int sbox_w);
        return size_state / sbox_w;
    endfunction

    function automatic int bits_per_rnd(input int size_state, input int sbox_w, input int kbits);
        return num_sbox(size_state, sbox_w) * kbits;
    endfunction

endpackage

// File: rtl/dizy_key_sched_if.sv
// Host/round-controller bus of the key scheduler: serial key load plus
// round-key request/response.
interface dizy_key_sched_if #(
    parameter int BUS_W      = 32,
    parameter int SIZE_STATE = 160
);
    logic                  key_clr;
    logic                  key_valid;
    logic                  key_ready;
    logic [BUS_W-1:0]      key_data;
    logic                  key_loaded;
    logic                  rk_req;
    logic [3:0]            rnd_cnt;
    logic                  rk_valid;
    logic                  rk_err;
    logic [SIZE_STATE-1:0] rk;

    modport master (
        output key_clr, key_valid, key_data, rk_req, rnd_cnt,
        input  key_ready, key_loaded, rk_valid, rk_err, rk
    );

    modport slave (
        input  key_clr, key_valid, key_data, rk_req, rnd_cnt,
        output key_ready, key_loaded, rk_valid, rk_err, rk
    );
endinterface

// File: rtl/dizy_key_sched_spread.sv
// Combinational key spreader: selects the round's key slice and places
// KBITS of it at the MSBs of every S-box field, zero elsewhere.
module dizy_key_spread
    import dizy_key_sched_pkg::*;
#(
    parameter int SIZE_STATE = 160,
    parameter int SIZE_KEY   = 128,
    parameter int SBOX_W     = 5,
    parameter int KBITS      = 2
) (
    input  logic [SIZE_KEY-1:0]   i_key,
    input  logic [3:0]            i_rnd,
    output logic [SIZE_STATE-1:0] o_rk
);
    localparam int NUM_SBOX     = num_sbox(SIZE_STATE, SBOX_W);
    localparam int BITS_PER_RND = bits_per_rnd(SIZE_STATE, SBOX_W, KBITS);
    localparam int KEY_RNDS     = ceil_div(SIZE_KEY, BITS_PER_RND);
    localparam int PAD_W        = KEY_RNDS * BITS_PER_RND - SIZE_KEY;

    logic [KEY_RNDS*BITS_PER_RND-1:0] w_key_pad;
    logic [BITS_PER_RND-1:0]          w_slice [KEY_RNDS];
    logic [BITS_PER_RND-1:0]          w_sel;

    // The last slice runs past key[0]; those positions read as zero.
    if (PAD_W == 0) begin : g_nopad
        assign w_key_pad = i_key;
    end else begin : g_pad
        assign w_key_pad = {i_key, {PAD_W{1'b0}}};
    end

    for (genvar r = 0; r < KEY_RNDS; r++) begin : g_slice
        assign w_slice[r] = w_key_pad[KEY_RNDS*BITS_PER_RND-1-r*BITS_PER_RND -: BITS_PER_RND];
    end

    // NOTE: default first so every path assigns w_sel and no latch is inferred.
    always_comb begin
        w_sel = '0;
        for (int r = 0; r < KEY_RNDS; r++) begin
            if (i_rnd == 4'(r)) w_sel = w_slice[r];
        end
    end

    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_field
        if (KBITS == SBOX_W) begin : g_full
            assign o_rk[SBOX_W*(j+1)-1 -: SBOX_W] = w_sel[KBITS*(j+1)-1 -: KBITS];
        end else begin : g_part
            assign o_rk[SBOX_W*(j+1)-1 -: SBOX_W] =
                {w_sel[KBITS*(j+1)-1 -: KBITS], {(SBOX_W-KBITS){1'b0}}};
        end
    end
endmodule

// File: rtl/dizy_key_sched.sv
// Sequential DIZY key scheduler: loads the master key serially, then serves
// registered extended round keys one cycle after each request.
module dizy_key_sched
    import dizy_key_sched_pkg::*;
#(
    parameter int SIZE_STATE = DIZY128_SIZE_STATE,
    parameter int SIZE_KEY   = DIZY128_SIZE_KEY,
    parameter int SBOX_W     = DIZY_SBOX_W,
    parameter int KBITS      = DIZY_KBITS,
    parameter int BUS_W      = DIZY_BUS_W
) (
    input  logic            clk,
    input  logic            rst,
    dizy_key_sched_if.slave key_if
);
    localparam int BITS_PER_RND = bits_per_rnd(SIZE_STATE, SBOX_W, KBITS);
    localparam int KEY_RNDS     = ceil_div(SIZE_KEY, BITS_PER_RND);
    localparam int LOAD_BEATS   = ceil_div(SIZE_KEY, BUS_W);
    localparam int CNT_W        = $clog2(LOAD_BEATS + 1);

    if (SIZE_STATE % SBOX_W != 0) begin : g_chk_state
        $error("dizy_key_sched: SIZE_STATE must be a multiple of SBOX_W");
    end
    if (KBITS > SBOX_W) begin : g_chk_kbits
        $error("dizy_key_sched: KBITS must not exceed SBOX_W");
    end
    if (KEY_RNDS > 16) begin : g_chk_rnds
        $error("dizy_key_sched: KEY_RNDS must fit a 4-bit round counter");
    end

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [SIZE_KEY-1:0]   r_key;
    logic [SIZE_STATE-1:0] r_rk;
    logic                  r_rk_valid;
    logic                  r_rk_err;
    logic                  w_key_ready;
    logic                  w_accept;
    logic                  w_serve;
    logic [SIZE_STATE-1:0] w_rk;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_ready = (r_state != ST_ARMED) && !key_if.key_clr;
        w_accept    = key_if.key_valid && w_key_ready;
        if (key_if.key_clr) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY:   if (w_accept) w_state_nxt = (LOAD_BEATS == 1) ? ST_ARMED : ST_LOADING;
                ST_LOADING: if (w_accept && r_cnt == CNT_W'(LOAD_BEATS - 1)) w_state_nxt = ST_ARMED;
                ST_ARMED:   w_state_nxt = ST_ARMED;
                default:    w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    // Only the low SIZE_KEY bits of the beat stream are kept; excess first-beat bits fall off the top.
    always_ff @(posedge clk) begin
        if (rst || key_if.key_clr) begin
            r_cnt <= '0;
            r_key <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            r_key <= SIZE_KEY'({r_key, key_if.key_data});
        end
    end

    dizy_key_spread #(
        .SIZE_STATE (SIZE_STATE),
        .SIZE_KEY   (SIZE_KEY),
        .SBOX_W     (SBOX_W),
        .KBITS      (KBITS)
    ) u_spread (
        .i_key (r_key),
        .i_rnd (key_if.rnd_cnt),
        .o_rk  (w_rk)
    );

    // A clear in the request cycle, or any request before ARMED, yields an error response.
    assign w_serve = (r_state == ST_ARMED) && !key_if.key_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk       <= '0;
            r_rk_valid <= 1'b0;
            r_rk_err   <= 1'b0;
        end else begin
            r_rk_valid <= key_if.rk_req;
            r_rk_err   <= key_if.rk_req && !w_serve;
            if (key_if.rk_req) r_rk <= w_serve ? w_rk : '0;
        end
    end

    assign key_if.key_ready  = w_key_ready;
    assign key_if.key_loaded = (r_state == ST_ARMED);
    assign key_if.rk_valid   = r_rk_valid;
    assign key_if.rk_err     = r_rk_err;
    assign key_if.rk         = r_rk;
endmodule

// File: tb/tb_dizy_key_sched.sv
// Bench driving a DIZY-128 and a DIZY-80 scheduler with identical stimulus,
// each checked every cycle against a queue-of-beats reference model.
module tb_dizy_key_sched;
    import dizy_key_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_clr, s_valid, s_req;
    logic [31:0] s_data;
    logic [3:0]  s_rnd;

    int total = 0;
    int bad   = 0;

    dizy_key_sched_if #(.BUS_W(32), .SIZE_STATE(DIZY128_SIZE_STATE)) ifc128 ();
    dizy_key_sched_if #(.BUS_W(32), .SIZE_STATE(DIZY80_SIZE_STATE))  ifc80 ();

    assign ifc128.key_clr   = s_clr;
    assign ifc128.key_valid = s_valid;
    assign ifc128.key_data  = s_data;
    assign ifc128.rk_req    = s_req;
    assign ifc128.rnd_cnt   = s_rnd;
    assign ifc80.key_clr    = s_clr;
    assign ifc80.key_valid  = s_valid;
    assign ifc80.key_data   = s_data;
    assign ifc80.rk_req     = s_req;
    assign ifc80.rnd_cnt    = s_rnd;

    dizy_key_sched #(
        .SIZE_STATE (DIZY128_SIZE_STATE),
        .SIZE_KEY   (DIZY128_SIZE_KEY),
        .SBOX_W     (5),
        .KBITS      (2),
        .BUS_W      (32)
    ) u_dut128 (
        .clk    (clk),
        .rst    (rst),
        .key_if (ifc128.slave)
    );

    dizy_key_sched #(
        .SIZE_STATE (DIZY80_SIZE_STATE),
        .SIZE_KEY   (DIZY80_SIZE_KEY),
        .SBOX_W     (5),
        .KBITS      (2),
        .BUS_W      (32)
    ) u_dut80 (
        .clk    (clk),
        .rst    (rst),
        .key_if (ifc80.slave)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 is DIZY-128, index 1 is DIZY-80.
    int           m_n [2];
    logic [31:0]  m_beats [2][4];
    logic [159:0] m_rk [2];
    logic         m_valid [2];
    logic         m_err [2];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int v_key(input int v);
        return (v == 0) ? 128 : 80;
    endfunction

    function automatic int v_state(input int v);
        return (v == 0) ? 160 : 120;
    endfunction

    function automatic logic m_armed(input int v);
        return m_n[v] == (v_key(v) + 31) / 32;
    endfunction

    function automatic logic [127:0] model_key(input int v);
        logic [127:0] full = '0;
        for (int i = 0; i < m_n[v]; i++) full = (full << 32) | {96'd0, m_beats[v][i]};
        if (v_key(v) < 128) full = full & ((128'd1 << v_key(v)) - 128'd1);
        return full;
    endfunction

    // Field j gets slice bits {2j+1, 2j} at positions {5j+4, 5j+3}.
    function automatic logic [159:0] model_rk(input int v, input logic [127:0] key, input int r);
        logic [159:0] rk = '0;
        int ns   = v_state(v) / 5;
        int bpr  = ns * 2;
        int nrnd = (v_key(v) + bpr - 1) / bpr;
        if (r >= nrnd) return rk;
        for (int j = 0; j < ns; j++) begin
            for (int b = 0; b < 2; b++) begin
                int k   = 2 * j + b;
                int idx = v_key(v) - 1 - r * bpr - (bpr - 1 - k);
                if (idx >= 0) rk[5 * j + 3 + b] = key[idx];
            end
        end
        return rk;
    endfunction

    task automatic model_update(input int v, input logic t_rst, input logic t_clr,
                                input logic t_valid, input logic [31:0] t_data,
                                input logic t_req, input logic [3:0] t_rnd);
        if (t_rst) begin
            m_n[v] = 0; m_rk[v] = '0; m_valid[v] = 1'b0; m_err[v] = 1'b0;
        end else begin
            m_valid[v] = t_req;
            m_err[v]   = 1'b0;
            if (t_req) begin
                if (t_clr || !m_armed(v)) begin
                    m_rk[v] = '0; m_err[v] = 1'b1;
                end else begin
                    m_rk[v] = model_rk(v, model_key(v), int'(t_rnd));
                end
            end
            if (t_clr) m_n[v] = 0;
            else if (t_valid && !m_armed(v)) begin
                m_beats[v][m_n[v]] = t_data;
                m_n[v]++;
            end
        end
    endtask

    // Called at a falling edge: check registered outputs, drive, check ready, clock once.
    task automatic step(input logic t_rst, input logic t_clr, input logic t_valid,
                        input logic [31:0] t_data, input logic t_req, input logic [3:0] t_rnd);
        check("rk_valid128", 160'(ifc128.rk_valid),  160'(m_valid[0]));
        check("rk_err128",   160'(ifc128.rk_err),    160'(m_err[0]));
        check("rk128",       160'(ifc128.rk),        m_rk[0]);
        check("loaded128",   160'(ifc128.key_loaded), 160'(m_armed(0)));
        check("rk_valid80",  160'(ifc80.rk_valid),   160'(m_valid[1]));
        check("rk_err80",    160'(ifc80.rk_err),     160'(m_err[1]));
        check("rk80",        160'(ifc80.rk),         m_rk[1]);
        check("loaded80",    160'(ifc80.key_loaded), 160'(m_armed(1)));
        rst = t_rst; s_clr = t_clr; s_valid = t_valid; s_data = t_data; s_req = t_req; s_rnd = t_rnd;
        #1;
        check("ready128", 160'(ifc128.key_ready), 160'(!m_armed(0) && !t_clr));
        check("ready80",  160'(ifc80.key_ready),  160'(!m_armed(1) && !t_clr));
        @(posedge clk);
        model_update(0, t_rst, t_clr, t_valid, t_data, t_req, t_rnd);
        model_update(1, t_rst, t_clr, t_valid, t_data, t_req, t_rnd);
        @(negedge clk);
    endtask

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    initial begin
        rst = 1'b1; s_clr = 1'b0; s_valid = 1'b0; s_data = '0; s_req = 1'b0; s_rnd = '0;
        for (int v = 0; v < 2; v++) begin
            m_n[v] = 0; m_rk[v] = '0; m_valid[v] = 1'b0; m_err[v] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);

        // Request while EMPTY
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd0);
        check("pre_err128", 160'(ifc128.rk_err), 160'd1);
        check("pre_rk128", 160'(ifc128.rk), 160'd0);

        // DIZY-80 arms on 0,0,ones; DIZY-128 takes a 4th beat
        step(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, ONES, 1'b0, 4'd0);
        check("d80_loaded", 160'(ifc80.key_loaded), 160'd1);
        step(1'b0, 1'b0, 1'b1, ONES, 1'b0, 4'd0);
        check("d128_loaded", 160'(ifc128.key_loaded), 160'd1);

        // Back-to-back requests 0,1,2,0
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd0);
        check("d80_rnd0", 160'(ifc80.rk), 160'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd1);
        check("d80_rnd1", 160'(ifc80.rk), 160'({{16{5'b11000}}, 40'd0}));
        check("d80_err", 160'(ifc80.rk_err), 160'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd2);
        check("d80_rnd2", 160'(ifc80.rk), 160'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd0);

        // Beat while ARMED is ignored
        step(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd1);
        check("d80_keep", 160'(ifc80.rk), 160'({{16{5'b11000}}, 40'd0}));

        // Clear, partial load, clear with a dropped beat, then reload all ones
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 32'h5A5A_F0F0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, ONES, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, ONES, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, ONES, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, ONES, 1'b1, 4'd0);
        check("final_beat_err128", 160'(ifc128.rk_err), 160'd1);
        check("d80_ones", 160'(ifc80.rk), 160'({24{5'b11000}}));
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd0);
        check("d128_rnd0", 160'(ifc128.rk), {32{5'b11000}});
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd1);
        check("d128_rnd1", 160'(ifc128.rk), {32{5'b11000}});
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd2);
        check("d128_rnd2", 160'(ifc128.rk), 160'd0);

        // Reset mid-load together with a request
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 4'd0);
        check("rst_valid", 160'(ifc128.rk_valid), 160'd0);
        check("rst_ready", 160'(ifc128.key_ready), 160'd1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic       r_rst, r_clr, r_val, r_req;
            logic [3:0] r_rnd;
            r_rst = ($urandom_range(0, 99) < 1);
            r_clr = ($urandom_range(0, 99) < 4);
            r_val = ($urandom_range(0, 99) < 55);
            r_req = ($urandom_range(0, 99) < 35);
            r_rnd = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            step(r_rst, r_clr, r_val, $urandom, r_req, r_rnd);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end
endmodule
